// File: rtl/im_loader.sv
// im_loader
//
// Receives a program image as a byte stream over a valid/ready handshake,
// assembles big-endian 32-bit words and issues single-cycle word writes into
// the instruction memory, starting at START_ADDRESS. The core is held idle
// through `busy` until the image has been loaded (and, optionally, verified).
//
// Stream format: LEN_HI, LEN_LO (16-bit big-endian word count N), N*4 data
// bytes MSB first, then, with IM_LOADER_CHECKSUM_EN defined, one checksum
// byte equal to the XOR of all data bytes.
//
// Build option:
//   IM_LOADER_CHECKSUM_EN  defined   -> trailing checksum byte is expected
//                                       and compared; mismatch sets `error`.
//                          undefined -> no checksum byte; load completes
//                                       right after the last word write.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   one-cycle pulse beginning a load (ignored while busy)
//   byte_in     in   [7:0] stream byte
//   byte_valid  in   byte_in is valid
//   byte_ready  out  loader accepts a byte this cycle
//   we          out  IM write strobe, one cycle per word
//   waddr       out  [31:0] IM byte address of the write
//   wdata       out  [31:0] IM write data
//   busy        out  load in progress
//   done        out  sticky: last load completed successfully
//   error       out  sticky: last load aborted
//   word_count  out  [CNT_WIDTH-1:0] words written in current/last load
//
// Assumes CNT_WIDTH <= 16 and CNT_WIDTH + 2 <= 32.

module im_loader #(
    parameter logic [31:0] START_ADDRESS = 32'h0000_3000,
    parameter int          MAX_WORDS     = 1024,
    parameter int          CNT_WIDTH     = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 we,
    output logic [31:0]          waddr,
    output logic [31:0]          wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [CNT_WIDTH-1:0] word_count
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
`ifdef IM_LOADER_CHECKSUM_EN
        S_WRITE  = 3'd4,
        S_CSUM   = 3'd5
`else
        S_WRITE  = 3'd4
`endif
    } state_t;

`ifdef IM_LOADER_CHECKSUM_EN
    // Running 8-bit XOR checksum over data bytes.
    function automatic logic [7:0] csum_next(input logic [7:0] acc,
                                             input logic [7:0] data);
        return acc ^ data;
    endfunction
`endif

    state_t                 state_r;
    logic [7:0]             len_hi_r;
    logic [CNT_WIDTH-1:0]   len_r;
    logic [23:0]            word_r;      // first three bytes of the word, MSB first
    logic [1:0]             byte_cnt_r;
    logic                   ready_r;
    logic                   we_r;
    logic [31:0]            waddr_r;
    logic [31:0]            wdata_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   error_r;
    logic [CNT_WIDTH-1:0]   count_r;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]             csum_r;
`endif

    logic                   accept_s;
    logic [15:0]            len_s;
    logic                   len_ok_s;
    logic                   last_word_s;
    logic [31:0]            addr_s;

    // ready_r is registered, so there is no path from byte_valid to byte_ready.
    assign accept_s    = byte_valid && ready_r;
    assign len_s       = {len_hi_r, byte_in};
    assign len_ok_s    = (len_s != 16'd0) && (len_s <= MAX_LEN);
    assign last_word_s = ((count_r + CNT_WIDTH'(1)) == len_r);
    // Word address of the word being completed; N <= MAX_WORDS so no wrap.
    assign addr_s      = START_ADDRESS + {{(30 - CNT_WIDTH){1'b0}}, count_r, 2'b00};

    // Loader state machine with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            len_hi_r   <= 8'd0;
            len_r      <= '0;
            word_r     <= 24'd0;
            byte_cnt_r <= 2'd0;
            ready_r    <= 1'b0;
            we_r       <= 1'b0;
            waddr_r    <= 32'd0;
            wdata_r    <= 32'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            count_r    <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            csum_r     <= 8'd0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        done_r     <= 1'b0;
                        error_r    <= 1'b0;
                        count_r    <= '0;
                        byte_cnt_r <= 2'd0;
`ifdef IM_LOADER_CHECKSUM_EN
                        csum_r     <= 8'd0;
`endif
                        busy_r     <= 1'b1;
                        ready_r    <= 1'b1;
                        state_r    <= S_LEN_HI;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end

                S_LEN_HI: begin
                    if (accept_s) begin
                        len_hi_r <= byte_in;
                        state_r  <= S_LEN_LO;
                    end
                end

                S_LEN_LO: begin
                    if (accept_s) begin
                        if (len_ok_s) begin
                            len_r   <= len_s[CNT_WIDTH-1:0];
                            state_r <= S_DATA;
                        end else begin
                            error_r <= 1'b1;
                            busy_r  <= 1'b0;
                            ready_r <= 1'b0;
                            state_r <= S_IDLE;
                        end
                    end
                end

                S_DATA: begin
                    if (accept_s) begin
`ifdef IM_LOADER_CHECKSUM_EN
                        csum_r <= csum_next(csum_r, byte_in);
`endif
                        if (byte_cnt_r == 2'd3) begin
                            wdata_r    <= {word_r, byte_in};
                            waddr_r    <= addr_s;
                            we_r       <= 1'b1;
                            ready_r    <= 1'b0;
                            byte_cnt_r <= 2'd0;
                            state_r    <= S_WRITE;
                        end else begin
                            word_r     <= {word_r[15:0], byte_in};
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                        end
                    end
                end

                S_WRITE: begin
                    we_r    <= 1'b0;
                    count_r <= count_r + CNT_WIDTH'(1);
                    if (last_word_s) begin
`ifdef IM_LOADER_CHECKSUM_EN
                        ready_r <= 1'b1;
                        state_r <= S_CSUM;
`else
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b0;
                        state_r <= S_IDLE;
`endif
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= S_DATA;
                    end
                end

`ifdef IM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (accept_s) begin
                        if (byte_in == csum_r) begin
                            done_r  <= 1'b1;
                        end else begin
                            error_r <= 1'b1;
                        end
                        busy_r  <= 1'b0;
                        ready_r <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
`endif

                default: begin
                    we_r    <= 1'b0;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign byte_ready = ready_r;
    assign we         = we_r;
    assign waddr      = waddr_r;
    assign wdata      = wdata_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign word_count = count_r;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: randomized byte streams with random
// valid gaps and stray start pulses, checked against a stream-level model
// (expected write list and final status computed from the image itself).
module tb_im_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] word_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] words_q[$];   // image words for the next load
    logic [63:0] got_q[$];     // observed {waddr, wdata} writes

    im_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Record every write strobe; the loader must never accept bytes while writing.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            got_q.push_back({waddr, wdata});
            check_val("ready_during_write", 32'(byte_ready), 32'd0);
        end
    end

    task automatic chk_reset_outputs();
        check_val("rst_byte_ready", 32'(byte_ready), 32'd0);
        check_val("rst_we",         32'(we),         32'd0);
        check_val("rst_waddr",      waddr,           32'd0);
        check_val("rst_wdata",      wdata,           32'd0);
        check_val("rst_busy",       32'(busy),       32'd0);
        check_val("rst_done",       32'(done),       32'd0);
        check_val("rst_error",      32'(error),      32'd0);
        check_val("rst_word_count", 32'(word_count), 32'd0);
    endtask

    // Entry/exit time: just after a rising edge.
    task automatic drive_byte(input logic [7:0] b, input int gap_max);
        int g;
        int waited;
        bit ok;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        for (int i = 0; i < g; i++) begin
            start = ($urandom_range(3, 0) == 0);   // stray start while busy
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        byte_in    = b;
        byte_valid = 1'b1;
        waited     = 0;
        ok         = 1'b0;
        while (!ok && waited < 40) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                waited++;
            end
        end
        byte_valid = 1'b0;
        byte_in    = $urandom_range(255, 0);
        if (!ok) check_val("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_start();
        start      = 1'b1;
        byte_valid = 1'b1;          // a byte offered while idle must not be taken
        @(negedge clk);
        check_val("ready_in_idle", 32'(byte_ready), 32'd0);
        @(posedge clk);
        #1;
        start      = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        check_val("start_busy",   32'(busy),       32'd1);
        check_val("start_ready",  32'(byte_ready), 32'd1);
        check_val("start_done",   32'(done),       32'd0);
        check_val("start_error",  32'(error),      32'd0);
        check_val("start_wcount", 32'(word_count), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Full load of words_q with declared length len; the model derives the
    // expected write list and final status straight from the stream contents.
    task automatic run_load(input int len, input bit force_cs, input logic [7:0] cs_val,
                            input int gap_max);
        logic [7:0]  stream[$];
        logic [15:0] l16;
        logic [7:0]  x;
        logic [7:0]  cs;
        bit          valid_len;
        bit          exp_done;
        int          exp_lat;
        int          lat;
        int          nexp;
        got_q.delete();
        l16       = 16'(len);
        valid_len = (len >= 1) && (len <= 1024);
        stream.push_back(l16[15:8]);
        stream.push_back(l16[7:0]);
        x = 8'd0;
        if (valid_len) begin
            for (int i = 0; i < len; i++) begin
                for (int b = 0; b < 4; b++) begin
                    stream.push_back(words_q[i][31-8*b -: 8]);
                    x = x ^ words_q[i][31-8*b -: 8];
                end
            end
        end
        cs = force_cs ? cs_val : x;
`ifdef IM_LOADER_CHECKSUM_EN
        if (valid_len) stream.push_back(cs);
        exp_done = valid_len && (cs == x);
        exp_lat  = 1;
`else
        exp_done = valid_len;
        exp_lat  = valid_len ? 2 : 1;
`endif
        do_start();
        foreach (stream[i]) drive_byte(stream[i], gap_max);
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (!busy || lat >= 20) break;
        end
        check_val("finish_latency", 32'(lat),        32'(exp_lat));
        check_val("end_done",       32'(done),       32'(exp_done));
        check_val("end_error",      32'(error),      32'(!exp_done));
        check_val("end_wcount",     32'(word_count), valid_len ? 32'(len) : 32'd0);
        check_val("end_ready",      32'(byte_ready), 32'd0);
        nexp = valid_len ? len : 0;
        check_val("num_writes", 32'(got_q.size()), 32'(nexp));
        for (int i = 0; i < nexp && i < got_q.size(); i++) begin
            check_val("write_addr", got_q[i][63:32], 32'h0000_3000 + 32'(4 * i));
            check_val("write_data", got_q[i][31:0],  words_q[i]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single word, correct checksum 0x1B.
        words_q = {32'h3C01_1234};
        run_load(1, 1'b1, 8'h1B, 0);

        // Three words, checksum 0x00.
        words_q = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        run_load(3, 1'b1, 8'h00, 0);

`ifdef IM_LOADER_CHECKSUM_EN
        // Bad checksum: word still written, error reported.
        words_q = {32'h3C01_1234};
        run_load(1, 1'b1, 8'h1C, 0);
`endif

        // Illegal lengths abort right after LEN_LO.
        words_q.delete();
        run_load(0, 1'b0, 8'h00, 0);
        run_load(1025, 1'b0, 8'h00, 0);

        // Largest legal image.
        words_q.delete();
        for (int i = 0; i < 1024; i++) words_q.push_back($urandom);
        run_load(1024, 1'b0, 8'h00, 0);

        // Random images with valid gaps, stray starts and occasional bad checksum.
        for (int t = 0; t < 8; t++) begin
            int len;
            len = int'($urandom_range(12, 1));
            words_q.delete();
            for (int i = 0; i < len; i++) words_q.push_back($urandom);
            run_load(len, ($urandom_range(3, 0) == 0), 8'($urandom_range(255, 0)), 3);
        end

        // Reset during the second word write of a 4-word load.
        words_q.delete();
        for (int i = 0; i < 4; i++) words_q.push_back($urandom);
        got_q.delete();
        do_start();
        drive_byte(8'h00, 0);
        drive_byte(8'h04, 0);
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 4; b++) drive_byte(words_q[i][31-8*b -: 8], 0);
        end
        @(negedge clk);
        check_val("mid_we",    32'(we), 32'd1);
        check_val("mid_waddr", waddr,   32'h0000_3004);
        check_val("mid_wdata", wdata,   words_q[1]);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("mid_num_writes", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check_val("mid_addr0", got_q[0][63:32], 32'h0000_3000);
            check_val("mid_data0", got_q[0][31:0],  words_q[0]);
        end

        // Fresh load after reset starts again at the base address.
        words_q = {32'($urandom)};
        run_load(1, 1'b0, 8'h00, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/im_loader.md
# im_loader

Write-side companion of the instruction memory: receives a program image as a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and issues single-cycle word writes into IM starting at the IM base address. It sits between the host/boot byte source and the IM write port, and holds the core idle (`busy`) until the image is fully loaded and verified.

## Interface
- `START_ADDRESS`, 32'h0000_3000, byte address written by the first word; must be word-aligned.
- `MAX_WORDS`, 1024, IM capacity in words; largest legal image length.
- `CNT_WIDTH`, 11, width of word counters; must hold `MAX_WORDS`.

- `clk`  in  1  system clock, rising-edge active.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load; ignored while `busy`.
- `byte_in`  in  8  stream byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `we`  out  1  IM write strobe, one cycle per word.
- `waddr`  out  32  IM byte address for the write.
- `wdata`  out  32  IM write data.
- `busy`  out  1  load in progress.
- `done`  out  1  sticky: last load completed successfully.
- `error`  out  1  sticky: last load aborted.
- `word_count`  out  CNT_WIDTH  words written in current/last load.

## Operation
- Byte accepted on a rising edge where `byte_valid && byte_ready`.
- Stream format: LEN_HI, LEN_LO (16-bit big-endian word count N), then N×4 data bytes (MSB first), then one checksum byte (XOR of all data bytes only; length bytes excluded).
- States: IDLE → LEN_HI → LEN_LO → DATA ⇄ WRITE → CSUM → IDLE; abort path → IDLE with `error`.
- IDLE: `byte_ready`=0; `start` clears `done`, `error`, `word_count`, checksum accumulator; → LEN_HI.
- LEN_LO accept: N==0 or N>`MAX_WORDS` → set `error`, → IDLE; else → DATA.
- DATA: shift byte into word register; on 4th byte → WRITE.
- WRITE (1 cycle): `we`=1, `waddr`=`START_ADDRESS` + 4×`word_count`, `wdata`=assembled word; `byte_ready`=0; `word_count` increments at end of cycle; → CSUM if `word_count`+1==N, else DATA.
- CSUM accept: byte == accumulator → set `done`; else set `error`; → IDLE.
- `busy`=1 in every state except IDLE.
- Arithmetic: address computed in 32 bits, no wrap possible since N≤`MAX_WORDS`; checksum 8-bit XOR.

## Timing
- Reset values: `byte_ready`=0, `we`=0, `waddr`=0, `wdata`=0, `busy`=0, `done`=0, `error`=0, `word_count`=0, state IDLE.
- All outputs registered or decoded from state only; no combinational path from `byte_valid` to `byte_ready`.
- `start` at edge k → `busy`=1 and `byte_ready`=1 from cycle k+1.
- 4th byte of a word accepted at edge k → `we`=1 during cycle k+1 → next byte accepted no earlier than edge k+2. Peak rate: 4 bytes per 5 cycles.
- `done`/`error` assert in the cycle after the final accepting edge, same cycle `busy` drops; hold until next `start` or `reset`.
- `byte_valid` low stalls any state indefinitely without effect.
- `start` while `busy`: ignored. `start` with `byte_valid` same cycle: byte not accepted (IDLE).
- `reset` mid-load: immediate return to IDLE, `we` drops asynchronously, partially written words remain in IM, `done`=`error`=0.

## Configuration
- `IM_LOADER_CHECKSUM_EN` defined: CSUM state present as above.
- Not defined: no checksum byte expected; WRITE of last word → IDLE with `done`=1 in the following cycle; `error` only from length check; accumulator logic absent.

## Test plan
- Single word: start, bytes 00 01 3C 01 12 34 1B -> one `we` pulse with `waddr`=0x3000, `wdata`=0x3C011234; `done`=1, `word_count`=1, `error`=0.
- Three words 0x11111111, 0x22222222, 0x33333333, checksum 0x00 -> `we` at 0x3000/0x3004/0x3008 in order, `byte_ready` low each WRITE cycle, `done`=1.
- Bad checksum: single-word stream with checksum 0x1C -> word still written, `error`=1, `done`=0, `busy`=0.
- Length 0 and length 1025 -> `error`=1 immediately after LEN_LO, no `we` ever, `byte_ready`=0 thereafter.
- Random `byte_valid` gaps and `start` pulses while busy -> same writes/result as gap-free run; extra `start` has no effect.
- `reset` asserted after 2nd word write of a 4-word load -> all outputs at reset values same cycle; fresh `start` then full 1-word load succeeds with `waddr`=0x3000.
